// File: rtl/fifo_get_controller.sv
// Read-side controller for the cell-based FIFO: one-hot read pointer, 4-phase get handshake,
// cell data mux and empty flag. Define FIFO_GET_UNDERFLOW_EN to add a sticky underflow error flag.
module fifo_get_controller #(
    parameter int unsigned N_CELLS    = 16,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_CELLS-1:0]            f_i,
    input  logic [N_CELLS*DATA_WIDTH-1:0] data_i,
    input  logic                          get_req_i,
    output logic                          get_ack_o,
    output logic [DATA_WIDTH-1:0]         get_data_o,
    output logic [N_CELLS-1:0]            en_get_o,
    output logic [N_CELLS-1:0]            rd_ptr_o,
    output logic                          empty_o
`ifdef FIFO_GET_UNDERFLOW_EN
    ,
    output logic                          err_underflow_o
`endif
);

    typedef enum logic [1:0] {StIdle, StGet, StAck} state_e;

    state_e                 state_q;
    logic [N_CELLS-1:0]     rd_ptr_q;
    logic [N_CELLS-1:0]     en_get_q;
    logic                   ack_q;
    logic [DATA_WIDTH-1:0]  data_q;
    logic [DATA_WIDTH-1:0]  sel_data;
    logic                   hit;

    assign empty_o = (f_i == '0);
    assign hit     = |(f_i & rd_ptr_q);

    // One-hot pointer makes the mux a plain AND-OR over the cells.
    always_comb begin
        sel_data = '0;
        for (int unsigned k = 0; k < N_CELLS; k++) begin
            if (rd_ptr_q[k]) begin
                sel_data = sel_data | data_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            rd_ptr_q <= N_CELLS'(1);
            en_get_q <= '0;
            ack_q    <= 1'b0;
            data_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    en_get_q <= '0;
                    ack_q    <= 1'b0;
                    if (get_req_i && hit) begin
                        state_q  <= StGet;
                        en_get_q <= rd_ptr_q;
                    end
                end
                StGet: begin
                    en_get_q <= '0;
                    data_q   <= sel_data;
                    rd_ptr_q <= {rd_ptr_q[N_CELLS-2:0], rd_ptr_q[N_CELLS-1]};
                    ack_q    <= 1'b1;
                    state_q  <= StAck;
                end
                StAck: begin
                    // Leaving only on a released request guarantees the next request is a fresh rise.
                    if (!get_req_i) begin
                        ack_q   <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q  <= StIdle;
                    en_get_q <= '0;
                    ack_q    <= 1'b0;
                end
            endcase
        end
    end

`ifdef FIFO_GET_UNDERFLOW_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (state_q == StIdle && get_req_i && empty_o) begin
            err_q <= 1'b1;
        end
    end

    assign err_underflow_o = err_q;
`endif

    assign get_ack_o  = ack_q;
    assign get_data_o = data_q;
    assign en_get_o   = en_get_q;
    assign rd_ptr_o   = rd_ptr_q;

endmodule

// File: tb/tb_fifo_get_controller.sv
// Self-checking bench for fifo_get_controller: vector table, hand-written corner sequences and
// randomized reads checked against a transaction-level model (read index plus last word).
module tb_fifo_get_controller;

    localparam int N = 16;
    localparam int W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     f_i;
    logic [N*W-1:0]   data_i;
    logic             get_req_i;
    logic             get_ack_o;
    logic [W-1:0]     get_data_o;
    logic [N-1:0]     en_get_o;
    logic [N-1:0]     rd_ptr_o;
    logic             empty_o;
`ifdef FIFO_GET_UNDERFLOW_EN
    logic             err_underflow_o;
`endif

    fifo_get_controller #(
        .N_CELLS    (N),
        .DATA_WIDTH (W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .f_i        (f_i),
        .data_i     (data_i),
        .get_req_i  (get_req_i),
        .get_ack_o  (get_ack_o),
        .get_data_o (get_data_o),
        .en_get_o   (en_get_o),
        .rd_ptr_o   (rd_ptr_o),
        .empty_o    (empty_o)
`ifdef FIFO_GET_UNDERFLOW_EN
        ,
        .err_underflow_o (err_underflow_o)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    logic [W-1:0] cells [N];

    typedef struct {
        logic [N-1:0] f;
        logic [W-1:0] val;
        bit           served;
        logic [N-1:0] exp_en;
        logic [W-1:0] exp_data;
        logic [N-1:0] exp_ptr;
    } vec_t;

    vec_t tbl [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_data();
        for (int k = 0; k < N; k++) data_i[k*W +: W] = cells[k];
    endtask

    task automatic do_reset();
        get_req_i = 1'b0;
        rst_n     = 1'b0;
        repeat (2) @(negedge clk);
        rst_n     = 1'b1;
    endtask

    // Called at a negedge with the DUT idle; leaves it idle at a negedge.
    task automatic txn(input string name, input logic [N-1:0] f, input bit served,
                       input logic [N-1:0] exp_en, input logic [W-1:0] exp_data,
                       input logic [N-1:0] exp_ptr, input int hold);
        f_i = f;
        drive_data();
        get_req_i = 1'b1;
        if (served) begin
            @(negedge clk);
            check({name, ".en"}, en_get_o, exp_en);
            check({name, ".ack0"}, get_ack_o, 0);
            check({name, ".empty"}, empty_o, (f == '0));
            @(negedge clk);
            check({name, ".en_off"}, en_get_o, 0);
            check({name, ".ack1"}, get_ack_o, 1);
            check({name, ".data"}, get_data_o, exp_data);
            check({name, ".ptr"}, rd_ptr_o, exp_ptr);
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                check({name, ".hold_ack"}, get_ack_o, 1);
                check({name, ".hold_data"}, get_data_o, exp_data);
            end
            get_req_i = 1'b0;
            @(negedge clk);
            check({name, ".ack_rel"}, get_ack_o, 0);
            check({name, ".en_rel"}, en_get_o, 0);
        end else begin
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                check({name, ".wait_en"}, en_get_o, 0);
                check({name, ".wait_ack"}, get_ack_o, 0);
            end
            get_req_i = 1'b0;
            @(negedge clk);
            check({name, ".ptr"}, rd_ptr_o, exp_ptr);
            check({name, ".data"}, get_data_o, exp_data);
        end
    endtask

    int           idx;
    logic [W-1:0] last;
    logic [N-1:0] f;
    bit           srv;

    initial begin
        tbl[0] = '{f: 16'h0001, val: 8'hA5, served: 1'b1, exp_en: 16'h0001, exp_data: 8'hA5, exp_ptr: 16'h0002};
        tbl[1] = '{f: 16'h0001, val: 8'h3C, served: 1'b0, exp_en: 16'h0000, exp_data: 8'hA5, exp_ptr: 16'h0002};
        tbl[2] = '{f: 16'h0006, val: 8'h3C, served: 1'b1, exp_en: 16'h0002, exp_data: 8'h3D, exp_ptr: 16'h0004};
        tbl[3] = '{f: 16'hFFFB, val: 8'h77, served: 1'b0, exp_en: 16'h0000, exp_data: 8'h3D, exp_ptr: 16'h0004};
        tbl[4] = '{f: 16'hFFFF, val: 8'h77, served: 1'b1, exp_en: 16'h0004, exp_data: 8'h79, exp_ptr: 16'h0008};

        f_i = '0;
        data_i = '0;
        get_req_i = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        do_reset();
        check("rst.ptr", rd_ptr_o, 16'h0001);
        check("rst.ack", get_ack_o, 0);
        check("rst.data", get_data_o, 0);
        check("rst.en", en_get_o, 0);
        check("rst.empty", empty_o, 1);
`ifdef FIFO_GET_UNDERFLOW_EN
        check("rst.err", err_underflow_o, 0);
`endif

        for (int r = 0; r < 5; r++) begin
            for (int k = 0; k < N; k++) cells[k] = tbl[r].val + W'(k);
            txn($sformatf("tbl%0d", r), tbl[r].f, tbl[r].served, tbl[r].exp_en,
                tbl[r].exp_data, tbl[r].exp_ptr, r % 3);
        end

        // Request against an empty FIFO waits; the cell filling while req is held starts a GET.
        do_reset();
        for (int k = 0; k < N; k++) cells[k] = 8'h40 + W'(k);
        drive_data();
        f_i = '0;
        get_req_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("wait.en", en_get_o, 0);
            check("wait.ack", get_ack_o, 0);
        end
        f_i = 16'h0001;
        @(negedge clk);
        check("wait.get_en", en_get_o, 16'h0001);
        @(negedge clk);
        check("wait.ack1", get_ack_o, 1);
        check("wait.data", get_data_o, 8'h40);
        get_req_i = 1'b0;
        @(negedge clk);
        check("wait.ack_rel", get_ack_o, 0);

        // Seventeen reads across the wrap boundary.
        do_reset();
        for (int k = 0; k < N; k++) cells[k] = W'(k);
        for (int i = 0; i < 17; i++) begin
            txn($sformatf("wrap%0d", i), 16'hFFFF, 1'b1, N'(1) << (i % N), W'(i % N),
                N'(1) << ((i + 1) % N), 0);
        end

        // Reset while the handshake sits in ACK.
        do_reset();
        for (int k = 0; k < N; k++) cells[k] = 8'hC0 + W'(k);
        drive_data();
        f_i = 16'h0001;
        get_req_i = 1'b1;
        repeat (2) @(negedge clk);
        check("midrst.in_ack", get_ack_o, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst.ack", get_ack_o, 0);
        check("midrst.ptr", rd_ptr_o, 16'h0001);
        check("midrst.data", get_data_o, 0);
        get_req_i = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

`ifdef FIFO_GET_UNDERFLOW_EN
        do_reset();
        f_i = '0;
        get_req_i = 1'b1;
        @(negedge clk);
        check("uf.set", err_underflow_o, 1);
        get_req_i = 1'b0;
        @(negedge clk);
        cells[0] = 8'h11;
        txn("uf.read", 16'h0001, 1'b1, 16'h0001, 8'h11, 16'h0002, 0);
        check("uf.sticky", err_underflow_o, 1);
        do_reset();
        check("uf.clear", err_underflow_o, 0);
`endif

        // Randomized reads against the index/last-word model.
        do_reset();
        idx  = 0;
        last = '0;
        for (int t = 0; t < 40; t++) begin
            f = N'($urandom);
            if ($urandom_range(0, 2) == 0) f[idx] = 1'b0;
            for (int k = 0; k < N; k++) cells[k] = W'($urandom);
            srv = f[idx];
            if (srv) begin
                txn($sformatf("rnd%0d", t), f, 1'b1, N'(1) << idx, cells[idx],
                    N'(1) << ((idx + 1) % N), int'($urandom_range(0, 3)));
                last = cells[idx];
                idx  = (idx + 1) % N;
            end else begin
                txn($sformatf("rnd%0d", t), f, 1'b0, '0, last, N'(1) << idx, 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/fifo_get_controller.md
Name: fifo_get_controller

Overview:
- Read-side (get) controller for the cell-based FIFO; counterpart to the put-side logic that fills cells and detects full.
- Tracks a one-hot read pointer over the cell array and serves a consumer over a 4-phase req/ack handshake.
- Muxes out the selected cell's data and pulses a one-hot get-enable to empty that cell.
- Also produces the FIFO empty flag.

Parameters:
- N_CELLS, 16, number of FIFO cells (≥2).
- DATA_WIDTH, 8, bits per cell.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- f_i  input  N_CELLS  per-cell full flags; bit k=1 means cell k holds data.
- data_i  input  N_CELLS*DATA_WIDTH  cell data, flattened; cell k at bits [k*DATA_WIDTH +: DATA_WIDTH].
- get_req_i  input  1  consumer request, 4-phase.
- get_ack_o  output  1  acknowledge; get_data_o is valid while high.
- get_data_o  output  DATA_WIDTH  registered read data.
- en_get_o  output  N_CELLS  one-hot, single-cycle pulse that clears the cell being read.
- rd_ptr_o  output  N_CELLS  one-hot read pointer.
- empty_o  output  1  high when f_i is all zeros; combinational.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE, rd_ptr_o=1 (cell 0), get_ack_o=0, get_data_o=0, en_get_o=0.
  - Reset applies mid-handshake too: ack drops next cycle; any pending GET is discarded and the pointer is not advanced.
- empty_o = (f_i == 0). Always valid, independent of state.
- FSM, 3 states:
  - IDLE:
    - en_get_o=0, get_ack_o=0.
    - If get_req_i=1 and (f_i & rd_ptr_o)!=0, go to GET.
    - Otherwise stay. A request against an empty pointed cell waits with no timeout.
  - GET (exactly 1 cycle):
    - en_get_o=rd_ptr_o.
    - get_data_o loads data_i slice of the pointed cell at the end of the cycle.
    - rd_ptr_o rotates left at the end of the cycle; bit N_CELLS-1 wraps to bit 0.
    - Next state is ACK.
  - ACK:
    - get_ack_o=1, en_get_o=0.
    - Stay while get_req_i=1; on get_req_i=0 go to IDLE.
- Latency: req seen in IDLE at edge t → en_get_o high in cycle t+1 → get_ack_o high from t+2.
- Throughput: minimum 3 cycles per word, plus the consumer's release time.
- get_data_o holds its value between GETs and changes only in GET.
- The pointer advances only in GET. A cell's full flag drops the cycle after en_get_o, which is driven by the cell, not by this block.
- get_req_i dropping in IDLE before service: no action.
- Request is ignored if it is held with get_req_i=1 on return to IDLE; the consumer must deassert it first. ACK exits only on req=0, so a new request is always a fresh rise.
- Simultaneous put into a different cell during GET: no interaction. The put side owns f_i.

Optional Feature:
- Macro: FIFO_GET_UNDERFLOW_EN.
- Defined:
  - Extra port err_underflow_o (output, 1).
  - Sticky flag, set on the cycle after IDLE sees get_req_i=1 while empty_o=1.
  - Cleared only by reset; reset value 0.
  - Handshake behaviour is otherwise unchanged.
- Undefined: port and logic absent; behaviour otherwise identical.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles → rd_ptr_o=16'h0001, get_ack_o=0, get_data_o=0, en_get_o=0, empty_o=1 with f_i=0.
- Single read: f_i=16'h0001, cell0=8'hA5, raise req → en_get_o=16'h0001 for exactly 1 cycle, ack from t+2 with get_data_o=8'hA5, rd_ptr_o=16'h0002; drop req → ack low next cycle.
- Wrap-around: drive 17 sequential reads with f_i held 16'hFFFF and cell k=k → data sequence 0..15 then 0; rd_ptr_o goes 16'h8000 → 16'h0001.
- Wait on empty: f_i=0, req high 10 cycles → no en_get_o, ack stays 0; set f_i[0]=1 → GET on the next cycle, normal ack follows.
- Reset mid-handshake: assert rst_n=0 while in ACK → ack=0, rd_ptr_o=16'h0001, get_data_o=0 next cycle.
- With FIFO_GET_UNDERFLOW_EN: req while f_i=0 → err_underflow_o=1 next cycle; it stays 1 through later valid reads until reset.
